// File: rtl/updown_seq_pkg.sv
// Shared definitions for the up/down triangle-wave sequencer slice.
package updown_seq_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int RND_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DONE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/count_updown_en.sv
// Loadable up/down counter; a load takes priority over counting.
module count_updown_en #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    output logic [WIDTH-1:0] count
);

    // mode = 1 counts up, mode = 0 counts down; the count holds when en and load are both low
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            if (mode) begin
                count <= count + WIDTH'(1);
            end else begin
                count <= count - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/updown_seq_ctrl.sv
// Sequences a loadable up/down counter as a bounded lo->hi->lo triangle wave
// for a programmed number of rounds, with host start/stop control.
module updown_seq_ctrl
    import updown_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int RND_W = RND_W_DEF
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] cfg_lo,
    input  logic [WIDTH-1:0] cfg_hi,
    input  logic [RND_W-1:0] cfg_rounds,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc,
    output logic             busy,
    output logic             done,
    output logic             err
);

    seq_state_e       state;
    seq_state_e       next_state;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [RND_W-1:0] rem_q;
    logic             inf_q;
    logic             err_q;

    logic             cnt_en;
    logic             cnt_load;
    logic             cnt_mode;
    logic             cfg_ok;
    logic             at_hi;
    logic             at_lo;
    logic             last_round;

    assign cfg_ok     = cfg_hi > cfg_lo;
    assign at_hi      = count == hi_q;
    assign at_lo      = count == lo_q;
    assign last_round = !inf_q && (rem_q == RND_W'(1));

    // At each turn-around the counter simply reverses direction, so hi-1 and lo+1
    // come out of the ordinary step and every bound value lasts one cycle.
    always_comb begin
        next_state = state;
        cnt_en     = 1'b0;
        cnt_load   = 1'b0;
        cnt_mode   = 1'b0;
        case (state)
            IDLE: begin
                if (start && cfg_ok) begin
                    cnt_load   = 1'b1;
                    next_state = UP;
                end
            end
            UP: begin
                if (stop) begin
                    next_state = IDLE;
                end else begin
                    cnt_en = 1'b1;
                    if (at_hi) begin
                        next_state = DOWN;
                    end else begin
                        cnt_mode = 1'b1;
                    end
                end
            end
            DOWN: begin
                if (stop) begin
                    next_state = IDLE;
                end else if (!at_lo) begin
                    cnt_en = 1'b1;
                end else if (last_round) begin
                    next_state = DONE;
                end else begin
                    cnt_en     = 1'b1;
                    cnt_mode   = 1'b1;
                    next_state = UP;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
            lo_q  <= '0;
            hi_q  <= '0;
            rem_q <= '0;
            inf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= next_state;
            err_q <= (state == IDLE) && start && !cfg_ok;
            if (state == IDLE && start && cfg_ok) begin
                lo_q  <= cfg_lo;
                hi_q  <= cfg_hi;
                rem_q <= cfg_rounds;
                inf_q <= cfg_rounds == '0;
            end else if (state == DOWN && at_lo && !stop && !inf_q && !last_round) begin
                rem_q <= rem_q - RND_W'(1);
            end
        end
    end

    count_updown_en #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk      (clk),
        .clr_n    (clr_n),
        .en       (cnt_en),
        .load     (cnt_load),
        .load_val (cfg_lo),
        .mode     (cnt_mode),
        .count    (count)
    );

    assign dir  = state == UP;
    assign busy = (state == UP) || (state == DOWN);
    assign done = state == DONE;
    assign err  = err_q;
    assign tc   = ((state == UP) && at_hi) || ((state == DOWN) && at_lo);

endmodule
